serial_parity_transmitter: RTL and testbench
============================================

// Module: serial_parity_transmitter
//
// PURPOSE
//   Transmit side of the serial-parity link. Accepts a parallel data word and
//   shifts it out one bit per clock on x, LSB first, then appends one parity bit.
//   With PARITY_ODD=0, the XOR of all DATA_WIDTH+1 bits in a frame is 0.
//   Feeds the serial parity detector directly and is also its stimulus source.
//
// PARAMETERS
//   DATA_WIDTH  8  bits per data word (>=2); frame length is DATA_WIDTH+1 cycles
//   PARITY_ODD  0  0 = even parity (frame XOR = 0), 1 = odd parity (frame XOR = 1)
//
// PORTS
//   clk      in   1           rising-edge clock
//   rst_n    in   1           asynchronous reset, active-low
//   data_in  in   DATA_WIDTH  word to send; sampled only on an accept edge
//   load     in   1           request to send data_in
//   ready    out  1           block can accept load this cycle
//   x        out  1           serial data/parity output, registered
//   busy     out  1           x carries a valid frame bit this cycle
//   done     out  1           1-cycle pulse, high while x carries the parity bit
//
// BEHAVIOUR
//   - Reset (rst_n=0, async): state=IDLE, x=0, busy=0, done=0, ready=1,
//     shift register and bit counter = 0. Any frame in progress is abandoned
//     immediately; no parity bit is sent for it.
//   - FSM states: IDLE, SHIFT, PARITY.
//     IDLE   : ready=1, busy=0, x=0. On (load & ready), go to SHIFT.
//     SHIFT  : busy=1, ready=0. x = current data bit.
//              After DATA_WIDTH cycles in SHIFT, go to PARITY.
//     PARITY : busy=1, done=1, ready=1. x = ^word ^ PARITY_ODD.
//              If load=1, go to SHIFT with the new word (back-to-back frame).
//              Otherwise, go to IDLE.
//   - Accept: at the clock edge where load & ready are both high, latch data_in.
//     In the next cycle, x = data_in[0]. Data bits follow on consecutive cycles
//     up to bit DATA_WIDTH-1, then the parity bit.
//   - Latency: first bit appears 1 cycle after accept. done is high in cycle
//     DATA_WIDTH+1 after accept.
//   - Parity is accumulated from the latched word. Changes on data_in after
//     accept have no effect on the frame.
//   - load while ready=0 (in SHIFT) is ignored and not queued.
//   - Back-to-back frames: load in PARITY produces a continuous bitstream with
//     no idle gap. busy stays 1 and done pulses once per frame.
//   - Bit counter width is $clog2(DATA_WIDTH). Counter wraps to 0 when entering
//     PARITY. Counter never exceeds DATA_WIDTH-1.
//   - x is driven only from flops: no combinational path from any input to x.
//
// TESTING
//   1. Reset, then load 8'hA5 with even parity. Required x over cycles 1..9 after
//      accept: 1,0,1,0,0,1,0,1,0. done=1 only in cycle 9. busy=1 in cycles 1..9.
//   2. Load 8'h07 with even parity. Required x: 1,1,1,0,0,0,0,0, then parity 1.
//      The XOR of all 9 bits is 0.
//   3. Set PARITY_ODD=1 and load 8'h00. Required x: eight 0s, then parity 1.
//      The XOR of the frame is 1.
//   4. Load 8'hFF, then hold load=1 with data_in=8'h01 through the parity cycle.
//      Required: parity bit 0, then immediately 1,0,0,0,0,0,0,0,1.
//      No idle cycle between frames; done pulses twice.
//   5. Pulse load with 8'h3C during cycle 4 of an 8'hA5 frame. Required: the
//      request is ignored, the 8'hA5 frame completes unchanged, and the block
//      returns to IDLE.
//   6. Assert rst_n=0 in cycle 5 of a frame. Required, asynchronously: x=0,
//      busy=0, done=0, ready=1. A new load after rst_n=1 sends a clean frame.

Source files
------------

// File: rtl/serial_parity_transmitter.sv
// Serial parity transmitter: shifts a latched word out LSB first on x, then
// appends one parity bit. Back-to-back frames are accepted during the parity cycle.
module serial_parity_transmitter #(
  parameter int DATA_WIDTH = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  load,
  output logic                  ready,
  output logic                  x,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            fsm_state
);

  localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CW-1:0]         cnt;
  logic                  par;

  assign fsm_state = state;

  // Handshake: a word is taken on the rising edge where load and ready are both 1.
  // ready is 1 in IDLE and PARITY; a load while ready is 0 is dropped, not queued.
  // shreg holds the not-yet-sent bits, cnt is the index of the bit now on x,
  // and par accumulates the XOR of every data bit already driven onto x.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      par   <= 1'b0;
      x     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ready <= 1'b1;
    end else begin
      case (state)
        SHIFT: begin
          if (cnt == LAST_BIT) begin
            state <= PARITY;
            cnt   <= '0;
            x     <= par ^ PARITY_ODD;
            done  <= 1'b1;
            ready <= 1'b1;
          end else begin
            cnt   <= cnt + CW'(1);
            x     <= shreg[0];
            par   <= par ^ shreg[0];
            shreg <= shreg >> 1;
          end
        end
        IDLE, PARITY: begin
          if (load && ready) begin
            // Bit 0 goes straight to x; the rest wait in shreg.
            state <= SHIFT;
            shreg <= data_in >> 1;
            cnt   <= '0;
            par   <= data_in[0];
            x     <= data_in[0];
            busy  <= 1'b1;
            done  <= 1'b0;
            ready <= 1'b0;
          end else begin
            state <= IDLE;
            cnt   <= '0;
            x     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            ready <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          x     <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_parity_transmitter.sv
// Bench for serial_parity_transmitter: an even-parity and an odd-parity instance,
// each with a frame scoreboard fed by the driver and drained by a monitor.
module tb_serial_parity_transmitter;

  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] data_e, data_o;
  logic          load_e, load_o;
  logic          ready_e, x_e, busy_e, done_e;
  logic          ready_o, x_o, busy_o, done_o;
  logic [1:0]    state_e, state_o;

  int checks;
  int failures;

  // Frames are stored as transmitted: bit i is the i-th bit seen on x.
  logic [DW:0] exp_q[$];
  logic [DW:0] exp_q_odd[$];

  serial_parity_transmitter #(.DATA_WIDTH(DW), .PARITY_ODD(1'b0)) dut_even (
    .clk(clk), .rst_n(rst_n), .data_in(data_e), .load(load_e),
    .ready(ready_e), .x(x_e), .busy(busy_e), .done(done_e), .fsm_state(state_e)
  );

  serial_parity_transmitter #(.DATA_WIDTH(DW), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .data_in(data_o), .load(load_o),
    .ready(ready_o), .x(x_o), .busy(busy_o), .done(done_o), .fsm_state(state_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Monitor, even instance
  logic [DW:0] col_e;
  int          n_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      col_e = '0;
      n_e   = 0;
    end else if (busy_e) begin
      if (n_e <= DW) col_e[n_e] = x_e;
      n_e++;
      if (done_e) begin
        chk("even_frame_len", n_e, DW + 1);
        if (exp_q.size() == 0) chk("even_unexpected_frame", {23'd0, col_e}, 32'hFFFF_FFFF);
        else chk("even_frame", {23'd0, col_e}, {23'd0, exp_q.pop_front()});
        col_e = '0;
        n_e   = 0;
      end else if (n_e > DW) begin
        chk("even_missing_done", n_e, DW + 1);
        n_e = 0;
      end
    end else if (done_e) begin
      chk("even_done_without_busy", done_e, 0);
    end
  end

  // Monitor, odd instance
  logic [DW:0] col_o;
  int          n_o;
  always @(negedge clk) begin
    if (!rst_n) begin
      col_o = '0;
      n_o   = 0;
    end else if (busy_o) begin
      if (n_o <= DW) col_o[n_o] = x_o;
      n_o++;
      if (done_o) begin
        chk("odd_frame_len", n_o, DW + 1);
        if (exp_q_odd.size() == 0) chk("odd_unexpected_frame", {23'd0, col_o}, 32'hFFFF_FFFF);
        else chk("odd_frame", {23'd0, col_o}, {23'd0, exp_q_odd.pop_front()});
        col_o = '0;
        n_o   = 0;
      end else if (n_o > DW) begin
        chk("odd_missing_done", n_o, DW + 1);
        n_o = 0;
      end
    end else if (done_o) begin
      chk("odd_done_without_busy", done_o, 0);
    end
  end

  // Driver tasks
  task automatic send_even(input logic [DW-1:0] d, input logic [DW:0] frame, input bit expect_frame);
    int t;
    t = 0;
    @(negedge clk);
    while (!ready_e && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!ready_e) chk("even_ready_timeout", ready_e, 1);
    data_e = d;
    load_e = 1'b1;
    if (expect_frame) exp_q.push_back(frame);
    @(posedge clk);
    #1;
    load_e = 1'b0;
    data_e = DW'($urandom_range(0, 255));
  endtask

  task automatic send_odd(input logic [DW-1:0] d, input logic [DW:0] frame);
    int t;
    t = 0;
    @(negedge clk);
    while (!ready_o && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!ready_o) chk("odd_ready_timeout", ready_o, 1);
    data_o = d;
    load_o = 1'b1;
    exp_q_odd.push_back(frame);
    @(posedge clk);
    #1;
    load_o = 1'b0;
    data_o = DW'($urandom_range(0, 255));
  endtask

  task automatic wait_idle_even();
    int t;
    t = 0;
    @(negedge clk);
    while (busy_e && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (busy_e) chk("even_idle_timeout", busy_e, 0);
  endtask

  task automatic wait_idle_odd();
    int t;
    t = 0;
    @(negedge clk);
    while (busy_o && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (busy_o) chk("odd_idle_timeout", busy_o, 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    load_e   = 1'b0;
    load_o   = 1'b0;
    data_e   = '0;
    data_o   = '0;
    repeat (3) @(negedge clk);
    chk("reset_x", x_e, 0);
    chk("reset_busy", busy_e, 0);
    chk("reset_done", done_e, 0);
    chk("reset_ready", ready_e, 1);
    chk("reset_state", state_e, 0);
    chk("reset_odd_x", x_o, 0);
    rst_n = 1'b1;

    // 1: A5 even, plus first-bit latency
    send_even(8'hA5, 9'h0A5, 1'b1);
    chk("t1_first_x", x_e, 1);
    chk("t1_busy", busy_e, 1);
    chk("t1_ready_low", ready_e, 0);
    wait_idle_even();
    chk("t1_ready_idle", ready_e, 1);

    // 2: 07 even
    send_even(8'h07, 9'h107, 1'b1);
    wait_idle_even();

    // 3: odd parity
    send_odd(8'h00, 9'h100);
    wait_idle_odd();
    send_odd(8'hFF, 9'h1FF);
    wait_idle_odd();
    send_odd(8'h01, 9'h001);
    wait_idle_odd();

    // 4: back-to-back FF then 01
    send_even(8'hFF, 9'h0FF, 1'b1);
    begin
      int t;
      t = 0;
      @(negedge clk);
      while (!done_e && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk("t4_done_seen", done_e, 1);
      chk("t4_parity_bit", x_e, 0);
      chk("t4_ready_in_parity", ready_e, 1);
    end
    data_e = 8'h01;
    load_e = 1'b1;
    exp_q.push_back(9'h101);
    @(posedge clk);
    #1;
    load_e = 1'b0;
    chk("t4_no_gap_busy", busy_e, 1);
    chk("t4_no_gap_x", x_e, 1);
    chk("t4_done_dropped", done_e, 0);
    wait_idle_even();

    // 5: load during cycle 4 of a frame is ignored
    send_even(8'hA5, 9'h0A5, 1'b1);
    repeat (4) @(negedge clk);
    chk("t5_ready_low", ready_e, 0);
    data_e = 8'h3C;
    load_e = 1'b1;
    @(posedge clk);
    #1;
    load_e = 1'b0;
    wait_idle_even();
    repeat (2) @(negedge clk);
    chk("t5_back_idle", state_e, 0);
    chk("t5_still_idle", busy_e, 0);

    // 6: async reset in cycle 5 abandons the frame
    send_even(8'hC3, 9'h000, 1'b0);
    repeat (5) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_x", x_e, 0);
    chk("t6_busy", busy_e, 0);
    chk("t6_done", done_e, 0);
    chk("t6_ready", ready_e, 1);
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    send_even(8'h5A, 9'h05A, 1'b1);
    wait_idle_even();
    send_even(8'h80, 9'h180, 1'b1);
    wait_idle_even();

    repeat (3) @(negedge clk);
    chk("even_queue_empty", exp_q.size(), 0);
    chk("odd_queue_empty", exp_q_odd.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
